// File: rtl/n101_mrom_icb_ctrl_pkg.sv
// Shared constants and the command error decode for the N101 mask-ROM ICB front-end.
package n101_mrom_icb_ctrl_pkg;

  localparam int MROM_AW     = 12;
  localparam int MROM_DW     = 32;
  localparam int MROM_ADDR_W = 32;
  localparam int MROM_RSP_DP = 2;

  // A command errors when it is a write or is not word aligned.
  function automatic logic cmd_is_err(input logic read, input logic [1:0] addr_lsb);
    return ~read | (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/n101_mrom_rsp_fifo.sv
// Response ring buffer: DP entries of W bits, in-order, with registered head output.
module n101_mrom_rsp_fifo #(
  parameter int DP = 2,
  parameter int W  = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [W-1:0]  mem [DP];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave cnt unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage written on push.
  // NOTE: storage has no reset; an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (cnt == CW'(DP));
  assign empty = (cnt == '0);
  // Masking an empty head keeps unwritten storage from reaching the outputs after reset.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/n101_mrom_icb_ctrl.sv
// ICB slave front-end for the N101 mask ROM: address slice, error decode, in-order responses.
module n101_mrom_icb_ctrl
  import n101_mrom_icb_ctrl_pkg::*;
#(
  parameter int AW     = MROM_AW,
  parameter int DW     = MROM_DW,
  parameter int ADDR_W = MROM_ADDR_W,
  parameter int RSP_DP = MROM_RSP_DP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_icb_cmd_valid,
  output logic              i_icb_cmd_ready,
  input  logic [ADDR_W-1:0] i_icb_cmd_addr,
  input  logic              i_icb_cmd_read,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i_icb_cmd_wmask,
  output logic              i_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic              i_icb_rsp_err,
  output logic [DW-1:0]     i_icb_rsp_rdata,
  output logic [AW-3:0]     rom_addr,
  input  logic [DW-1:0]     rom_dout
);

  logic          cmd_hsk;
  logic          rsp_hsk;
  logic          cmd_err;
  logic          buf_full;
  logic          buf_empty;
  logic [DW:0]   push_data;
  logic [DW:0]   head;
  logic          unused;

  // The ROM sees the word address every cycle; the window decode happened upstream.
  assign rom_addr = i_icb_cmd_addr[AW-1:2];

  assign cmd_err   = cmd_is_err(i_icb_cmd_read, i_icb_cmd_addr[1:0]);
  assign push_data = {cmd_err, cmd_err ? {DW{1'b0}} : rom_dout};

  // Ready depends on buffer occupancy only, never on rsp_ready.
  assign i_icb_cmd_ready = ~buf_full;
  assign i_icb_rsp_valid = ~buf_empty;
  assign cmd_hsk         = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rsp_hsk         = i_icb_rsp_valid & i_icb_rsp_ready;

  n101_mrom_rsp_fifo #(
    .DP (RSP_DP),
    .W  (DW + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_hsk),
    .push_data (push_data),
    .pop       (rsp_hsk),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head)
  );

  assign i_icb_rsp_err   = head[DW];
  assign i_icb_rsp_rdata = head[DW-1:0];

  // Write payload and out-of-window address bits have no effect on a ROM.
  assign unused = ^{i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_cmd_addr[ADDR_W-1:AW]};

endmodule

// File: tb/tb_n101_mrom_icb_ctrl.sv
// Self-checking bench for n101_mrom_icb_ctrl: directed steps, then randomized traffic against a queue model.
module tb_n101_mrom_icb_ctrl;

  localparam int DP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;

  logic [31:0] rom [1024];

  typedef struct {
    logic        err;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign rom_dout = rom[rom_addr];

  n101_mrom_icb_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (cmd_valid),
    .i_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_cmd_wmask (cmd_wmask),
    .i_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .i_icb_rsp_err   (rsp_err),
    .i_icb_rsp_rdata (rsp_rdata),
    .rom_addr        (rom_addr),
    .rom_dout        (rom_dout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response for a command, from the ROM contents and the access rules.
  function automatic ent_t expect_entry(input logic read, input logic [31:0] addr);
    ent_t e;
    int unsigned a = addr;
    e.err  = !read || (a % 4 != 0);
    e.data = e.err ? 32'h0 : rom[(a % 4096) / 4];
    return e;
  endfunction

  // One clock: drive at negedge, check outputs against the model, advance model at posedge.
  task automatic cycle(input logic v, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rr);
    bit   c_hsk, r_hsk;
    ent_t e;
    cmd_valid = v;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wmask = 4'hf;
    rsp_ready = rr;
    #1;
    check("rsp_valid", rsp_valid, q.size() != 0);
    check("cmd_ready", cmd_ready, q.size() < DP);
    check("rom_addr", rom_addr, (addr % 4096) / 4);
    if (q.size() != 0) begin
      check("rsp_err", rsp_err, q[0].err);
      check("rsp_rdata", rsp_rdata, q[0].data);
    end
    c_hsk = v && (q.size() < DP);
    r_hsk = rr && (q.size() != 0);
    e = expect_entry(rd, addr);
    @(posedge clk);
    if (r_hsk) void'(q.pop_front());
    if (c_hsk) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b1, 32'h0, 32'h0, rr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom();
    rom[0] = 32'h7ffff297;
    rom[1] = 32'h00028067;
    rom[2] = 32'h00028067;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_read  = 1'b1;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, one-cycle latency.
    cycle(1'b1, 1'b1, 32'h000, 32'h0, 1'b0);
    check("first_read_data", rsp_rdata, 32'h7ffff297);
    check("first_read_err", rsp_err, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back reads with rsp_ready held.
    cycle(1'b1, 1'b1, 32'h000, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h004, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h008, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: two accepted, third stalls, then drains in order.
    cycle(1'b1, 1'b1, 32'h000, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h004, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h008, 32'h0, 1'b0);
    check("full_stall_ready", cmd_ready, 1'b0);
    check("full_head_hold", rsp_rdata, 32'h7ffff297);
    cycle(1'b1, 1'b1, 32'h008, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h008, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Write and misaligned accesses error; a write leaves the ROM untouched; aliasing above AW.
    cycle(1'b1, 1'b0, 32'h004, 32'hdeadbeef, 1'b1);
    cycle(1'b1, 1'b1, 32'h004, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h006, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h1000, 32'h0, 1'b1);
    check("alias_word0", rsp_rdata, 32'h7ffff297);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset with two responses pending.
    cycle(1'b1, 1'b1, 32'h000, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h004, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 1'b0);
    check("async_rst_ready", cmd_ready, 1'b1);
    check("async_rst_rdata", rsp_rdata, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hffff_f000);
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, a, $urandom(),
            $urandom_range(0, 2) != 0);
    end
    repeat (4) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
